// File: rtl/axi_node_pkg.sv
// ---------------------------------------------------------------------------
// axi_node_pkg
// Shared types and constants for the AXI node master-port logic.
//   b_ord_state_e   : state of the write-response ordering FSM
//   B_SEL_NONE      : B-crossbar select that picks the default branch
//                     (no slave selected, all BREADY low)
//   SLV_NUM_DEFAULT : default number of slaves behind the node
// ---------------------------------------------------------------------------
package axi_node_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BUBBLE = 2'd2
    } b_ord_state_e;

    localparam logic [2:0] B_SEL_NONE      = 3'b111;
    localparam int         SLV_NUM_DEFAULT = 5;

endpackage

// File: rtl/b_order_fifo.sv
// ---------------------------------------------------------------------------
// b_order_fifo
// Small synchronous FIFO holding the slave index of each outstanding write.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   push, push_data    write one entry (caller guarantees not full)
//   pop                drop the head entry (caller guarantees not empty)
//   head               current head entry
//   head_next          head entry as it will be after this cycle's push/pop
//   count, count_next  occupancy now and after this cycle's push/pop
// Full/empty are taken from the occupancy counter; pointers simply wrap.
// ---------------------------------------------------------------------------
module b_order_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [WIDTH-1:0]           head_next,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    cnt_after_pop;

    always_comb begin
        rd_ptr_next   = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        cnt_after_pop = count_reg - CW'(pop);
        count_next    = count_reg + CW'(push) - CW'(pop);
        // When the FIFO drains to nothing this cycle, the new head is the
        // entry being written right now, which is not in the array yet.
        head_next     = (cnt_after_pop == '0) ? push_data : mem[rd_ptr_next];
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/b_order_ctrl.sv
// ---------------------------------------------------------------------------
// b_order_ctrl
// Write-response ordering controller for the AXI node master port. Every
// accepted AW records its target slave in an in-order FIFO; the B crossbar
// is steered to the oldest outstanding slave so responses return in AW
// order. AW issue is throttled when DEPTH writes are outstanding.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   aw_valid, aw_ready    master-side AW handshake
//   aw_slv_sel            decoded slave index of the current AW
//   b_valid, b_ready      B handshake at the crossbar master output
//   B_SLV_sel, B_hold     slave select / hold into the B crossbar
//   aw_stall              FIFO full, AW decoder must drop AWREADY
//   outstanding           FIFO occupancy
//   sel_err               one-cycle pulse: AW accepted with invalid index
//   b_timeout             sticky watchdog flag
// Optional feature: define B_ORDER_TIMEOUT_EN to build the response
// watchdog; otherwise b_timeout is tied low.
// ---------------------------------------------------------------------------
module b_order_ctrl
    import axi_node_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SLV_NUM     = SLV_NUM_DEFAULT,
    parameter int SEL_W       = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   aw_valid,
    input  logic                   aw_ready,
    input  logic [SEL_W-1:0]       aw_slv_sel,
    input  logic                   b_valid,
    input  logic                   b_ready,
    output logic [SEL_W-1:0]       B_SLV_sel,
    output logic                   B_hold,
    output logic                   aw_stall,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   sel_err,
    output logic                   b_timeout
);

    localparam int               CW       = $clog2(DEPTH) + 1;
    localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(B_SEL_NONE);
    localparam logic [SEL_W:0]   SLV_LIM  = (SEL_W + 1)'(SLV_NUM);

    b_ord_state_e     state_reg;
    logic [SEL_W-1:0] b_slv_sel_reg;
    logic             b_hold_reg;
    logic             aw_stall_reg;
    logic             sel_err_reg;

    logic             aw_hs;
    logic             sel_ok;
    logic             push;
    logic             pop;
    logic [SEL_W-1:0] head;
    logic [SEL_W-1:0] head_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;

    assign aw_hs  = aw_valid & aw_ready & ~aw_stall_reg;
    assign sel_ok = {1'b0, aw_slv_sel} < SLV_LIM;
    assign push   = aw_hs & sel_ok;
    // Only ACTIVE presents a live slave to the master; anything seen while
    // holding is a stale echo of the crossbar's registered output.
    assign pop    = b_valid & b_ready & (state_reg == ACTIVE);

    b_order_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SEL_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (aw_slv_sel),
        .pop        (pop),
        .head       (head),
        .head_next  (head_next),
        .count      (count),
        .count_next (count_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            b_slv_sel_reg <= SEL_NONE;
            b_hold_reg    <= 1'b1;
            aw_stall_reg  <= 1'b0;
            sel_err_reg   <= 1'b0;
        end else begin
            aw_stall_reg <= (count_next == CW'(DEPTH));
            sel_err_reg  <= aw_hs & ~sel_ok;
            case (state_reg)
                ACTIVE: begin
                    if (pop) begin
                        // One hold cycle while the crossbar output settles.
                        state_reg     <= BUBBLE;
                        b_hold_reg    <= 1'b1;
                        b_slv_sel_reg <= (count_next != '0) ? head_next : SEL_NONE;
                    end else begin
                        b_hold_reg    <= 1'b0;
                        b_slv_sel_reg <= head;
                    end
                end
                IDLE, BUBBLE: begin
                    if (count_next != '0) begin
                        state_reg     <= ACTIVE;
                        b_hold_reg    <= 1'b0;
                        b_slv_sel_reg <= head_next;
                    end else begin
                        state_reg     <= IDLE;
                        b_hold_reg    <= 1'b1;
                        b_slv_sel_reg <= SEL_NONE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    b_hold_reg    <= 1'b1;
                    b_slv_sel_reg <= SEL_NONE;
                end
            endcase
        end
    end

    assign B_SLV_sel   = b_slv_sel_reg;
    assign B_hold      = b_hold_reg;
    assign aw_stall    = aw_stall_reg;
    assign sel_err     = sel_err_reg;
    assign outstanding = count;

`ifdef B_ORDER_TIMEOUT_EN
    // Counts consecutive ACTIVE cycles without a response; saturates so a
    // very long wait cannot wrap back below the limit.
    logic [15:0] wd_cnt_reg;
    logic        b_timeout_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_reg    <= '0;
            b_timeout_reg <= 1'b0;
        end else begin
            if ((state_reg == ACTIVE) && !pop) begin
                if (wd_cnt_reg != 16'hFFFF) begin
                    wd_cnt_reg <= wd_cnt_reg + 16'd1;
                end
                if (wd_cnt_reg == 16'(TIMEOUT_CYC - 1)) begin
                    b_timeout_reg <= 1'b1;
                end
            end else begin
                wd_cnt_reg <= '0;
            end
        end
    end

    assign b_timeout = b_timeout_reg;
`else
    assign b_timeout = 1'b0;
`endif

endmodule

// File: doc/b_order_ctrl.md
Name: b_order_ctrl

Overview:
- Write-response ordering controller for the AXI node master port.
- Records the target slave index of every accepted AW transaction in an in-order FIFO.
- Drives slave-select and hold into the downstream B-channel crossbar, so write responses return to the master in AW issue order.
- Throttles AW issue when the outstanding-write limit is reached.

Parameters:
- DEPTH, 8, max outstanding write transactions; power of two, ≥2
- SLV_NUM, 5, number of slaves; valid select values are 0..SLV_NUM-1
- SEL_W, 3, width of slave-select fields
- TIMEOUT_CYC, 1024, watchdog limit in cycles (optional feature only)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- aw_valid  in  1  master-side AWVALID
- aw_ready  in  1  master-side AWREADY
- aw_slv_sel  in  SEL_W  decoded slave index of the current AW
- b_valid  in  1  m_BVALID seen at the crossbar master output
- b_ready  in  1  m_BREADY from the master
- B_SLV_sel  out  SEL_W  slave select to the B crossbar
- B_hold  out  1  hold to the B crossbar
- aw_stall  out  1  FIFO full; AW decoder must deassert AWREADY
- outstanding  out  $clog2(DEPTH)+1  current FIFO occupancy
- sel_err  out  1  one-cycle pulse: AW accepted with invalid aw_slv_sel
- b_timeout  out  1  sticky watchdog flag (optional feature only)

Behaviour:
- Reset values:
  - FIFO pointers = 0, outstanding = 0.
  - B_SLV_sel = 3'b111 (crossbar default branch; all BREADY low).
  - B_hold = 1, aw_stall = 0, sel_err = 0, b_timeout = 0.
  - Reset mid-operation discards all entries immediately.
- Push:
  - Occurs on aw_valid & aw_ready & !aw_stall & (aw_slv_sel < SLV_NUM).
  - Writes aw_slv_sel at the write pointer.
  - An invalid index with a handshake is not pushed; sel_err pulses high for exactly one cycle, registered.
- Pop: occurs on b_valid & b_ready while state is ACTIVE.
- aw_stall = (outstanding == DEPTH), registered from next-state occupancy.
- Pointer rules:
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Full/empty are derived from outstanding, not from pointer compare.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
  - Allowed when full, because the pop frees a slot.
  - aw_stall is still high that cycle, so no push actually occurs when full.
- FSM (registered outputs):
  - IDLE:
    - B_hold = 1, B_SLV_sel = 3'b111.
    - Go to ACTIVE when outstanding becomes nonzero.
    - Entry pushed at cycle N produces B_SLV_sel = head and B_hold = 0 at cycle N+1.
  - ACTIVE:
    - B_SLV_sel = FIFO head, B_hold = 0.
    - On pop, go to BUBBLE.
  - BUBBLE:
    - B_hold = 1 for exactly one cycle, B_SLV_sel = new head, or 3'b111 if empty.
    - Purpose: absorb the crossbar's one-cycle registered output so a stale BVALID/BREADY is not counted twice.
    - Then go to ACTIVE if not empty, else IDLE.
- b_valid/b_ready outside ACTIVE are ignored (no pop, no error).
- Pop with FIFO empty cannot occur, because state ACTIVE implies non-empty.

Optional Feature:
- Macro: B_ORDER_TIMEOUT_EN
- Defined:
  - A 16-bit counter increments each cycle in ACTIVE with no pop.
  - It clears on pop or on leaving ACTIVE.
  - When it reaches TIMEOUT_CYC-1, b_timeout sets and stays set until reset.
  - Occupancy and FSM are unaffected.
- Undefined: counter removed; b_timeout tied to 0.

Decomposition:
- Shared package axi_node_pkg holds:
  - state enum b_ord_state_e {IDLE, ACTIVE, BUBBLE}
  - constant B_SEL_NONE = 3'b111
  - default SLV_NUM
- One sub-module: b_order_fifo (sync FIFO, parameter DEPTH/WIDTH, push/pop/head/count).
  - The FSM, error and timeout logic stay in b_order_ctrl.

Test Plan:
- Reset check: reset_n low mid-traffic with 3 entries → next cycle outstanding=0, B_hold=1, B_SLV_sel=3'b111, aw_stall=0.
- Ordering: push slaves 2,0,4; return B from 4, 0, 2 in random timing → B_SLV_sel presents 2, then 0, then 4.
  - Each selection is preceded by one B_hold=1 bubble cycle after each pop.
  - Out-of-order BVALID from non-selected slaves is never forwarded.
- Full: push 8 entries with no B → aw_stall=1 and outstanding=8.
  - A 9th AW handshake attempt is not recorded.
  - One pop → aw_stall drops the following cycle.
- Simultaneous: at outstanding=3, push slave 1 and pop in the same cycle → outstanding stays 3; slave 1 appears after the two older entries.
- Invalid select: AW handshake with aw_slv_sel=6 → sel_err high for one cycle, outstanding unchanged.
- Timeout (B_ORDER_TIMEOUT_EN, TIMEOUT_CYC=16): one entry, b_valid held 0 → b_timeout=1 after 16 ACTIVE cycles and stays 1 after a later pop.
  - Without the macro, b_timeout stays 0.
